// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 raster and its consumers.
package vga_pkg;

  // Horizontal timing in pixels
  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  // Vertical timing in lines
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 100 MHz board clock down to a 25 MHz pixel rate
  localparam int unsigned VGA_TICK_DIV  = 4;

  // Width of the x/y coordinate buses
  localparam int unsigned COORD_W       = 10;

  // Sync pulses are active-low for the standard 640x480 mode
  localparam logic        SYNC_ACTIVE_LOW = 1'b0;

endpackage

// File: rtl/vga_tick_div.sv
// Clock-enable divider: one-clk pulse every TICK_DIV clks, registered.
module vga_tick_div #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned           CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;
  logic             r_tick;

  // Free-running modulo-TICK_DIV counter; tick lands the clk after the terminal count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= (r_div_cnt == CNT_LAST);
      r_div_cnt <= (r_div_cnt == CNT_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, h/v counters, registered syncs, video_on, frame strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT     = VGA_V_FRONT,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BACK      = VGA_V_BACK,
  parameter int unsigned TICK_DIV    = VGA_TICK_DIV,
  parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_LOW
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_tick
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_DISP_C = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_DISP_C = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic               w_p_tick;
  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic [COORD_W-1:0] w_h_next;
  logic [COORD_W-1:0] w_v_next;
  logic               w_hs_active;
  logic               w_vs_active;
  logic               r_hsync;
  logic               r_vsync;

  vga_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_p_tick)
  );

  // Next raster position and sync decode of that position, so the registered
  // syncs land on the same edge as the coordinates they describe
  always_comb begin
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (r_h_cnt == H_LAST) begin
      w_h_next = '0;
      w_v_next = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      w_h_next = r_h_cnt + 1'b1;
    end
    w_hs_active = (w_h_next >= HS_START) && (w_h_next <= HS_END);
    w_vs_active = (w_v_next >= VS_START) && (w_v_next <= VS_END);
  end

  // Raster counters and sync registers advance only on pixel ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hsync <= ~SYNC_ACTIVE;
      r_vsync <= ~SYNC_ACTIVE;
    end else if (w_p_tick) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
      r_hsync <= w_hs_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync <= w_vs_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign p_tick     = w_p_tick;
  assign x          = r_h_cnt;
  assign y          = r_v_cnt;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = (r_h_cnt < H_DISP_C) && (r_v_cnt < V_DISP_C);
  assign frame_tick = w_p_tick && (r_h_cnt == '0) && (r_v_cnt == V_DISP_C);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance
// for full-frame, wrap and frame-strobe behaviour within a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default timing
  logic       rst_a;
  logic       pt_a, hs_a, vs_a, vo_a, ft_a;
  logic [9:0] x_a, y_a;

  vga_timing_gen u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .p_tick     (pt_a),
    .hsync      (hs_a),
    .vsync      (vs_a),
    .video_on   (vo_a),
    .x          (x_a),
    .y          (y_a),
    .frame_tick (ft_a)
  );

  // Instance B: 15x11 raster, divide-by-3, active-high syncs
  localparam int unsigned BH = 15;
  localparam int unsigned BV = 11;
  logic       rst_b;
  logic       pt_b, hs_b, vs_b, vo_b, ft_b;
  logic [9:0] x_b, y_b;

  vga_timing_gen #(
    .H_DISPLAY   (8),
    .H_FRONT     (2),
    .H_SYNC      (3),
    .H_BACK      (2),
    .V_DISPLAY   (6),
    .V_FRONT     (1),
    .V_SYNC      (2),
    .V_BACK      (2),
    .TICK_DIV    (3),
    .SYNC_ACTIVE (1'b1)
  ) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .p_tick     (pt_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .video_on   (vo_b),
    .x          (x_b),
    .y          (y_b),
    .frame_tick (ft_b)
  );

  // Selected-instance view used by the shared tasks
  logic       sel_b = 1'b0;
  logic       cur_pt, cur_hs, cur_vs, cur_vo, cur_ft;
  logic [9:0] cur_x, cur_y;
  assign cur_pt = sel_b ? pt_b : pt_a;
  assign cur_hs = sel_b ? hs_b : hs_a;
  assign cur_vs = sel_b ? vs_b : vs_a;
  assign cur_vo = sel_b ? vo_b : vo_a;
  assign cur_ft = sel_b ? ft_b : ft_a;
  assign cur_x  = sel_b ? x_b  : x_a;
  assign cur_y  = sel_b ? y_b  : y_a;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned mx = 0, my = 0;

  // Frame strobe monitor for instance B
  logic        mon_en   = 1'b0;
  int unsigned clk_cnt  = 0;
  int unsigned ft_cnt   = 0;
  int unsigned ft_last  = 0;
  int unsigned ft_intv  = 0;
  int unsigned ft_bad   = 0;
  int unsigned ft_wide  = 0;
  logic        ft_prev  = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      clk_cnt = clk_cnt + 1;
      if (ft_b === 1'b1) begin
        ft_cnt = ft_cnt + 1;
        if (ft_cnt > 1) ft_intv = clk_cnt - ft_last;
        ft_last = clk_cnt;
        if (!(x_b == 10'd0 && y_b == 10'd6)) ft_bad = ft_bad + 1;
        if (ft_prev === 1'b1) ft_wide = ft_wide + 1;
      end
      ft_prev = ft_b;
    end
  end

  typedef struct {
    int unsigned x;
    int unsigned y;
    logic        hs;
    logic        vs;
    logic        vo;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // Advance through exactly one counter update (edge where p_tick is sampled high)
  task automatic step_tick();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      if (cur_pt === 1'b1) done = 1'b1;
      clk_step();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ptick_timeout actual=0 expected=1 (t=%0t)", $time);
    end
  endtask

  // Stop at a sample point where p_tick is high, without consuming it
  task automatic wait_pt_high();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      if (cur_pt === 1'b1) done = 1'b1;
      else clk_step();
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ptick_wait_timeout actual=0 expected=1 (t=%0t)", $time);
    end
  endtask

  task automatic adv_to(input int unsigned tx, input int unsigned ty, input int unsigned htot);
    int unsigned n;
    n = (ty * htot + tx) - (my * htot + mx);
    for (int unsigned i = 0; i < n; i++) step_tick();
    mx = tx;
    my = ty;
  endtask

  // Called right after reset is deasserted: first p_tick div clks later, x 0 -> 1 after it
  task automatic release_check(input int unsigned div);
    int unsigned first;
    logic [9:0]  x_at_first;
    first      = 0;
    x_at_first = '1;
    for (int unsigned k = 1; k <= div + 1; k++) begin
      clk_step();
      if (cur_pt === 1'b1 && first == 0) begin
        first      = k;
        x_at_first = cur_x;
      end
    end
    check("first_ptick_clk", first, div);
    check("x_at_first_ptick", x_at_first, 0);
    check("x_after_first_ptick", cur_x, 1);
    mx = 1;
    my = 0;
  endtask

  task automatic check_reset_state(input string tag, input logic idle_sync);
    check({tag, "_x"}, cur_x, 0);
    check({tag, "_y"}, cur_y, 0);
    check({tag, "_ptick"}, cur_pt, 0);
    check({tag, "_hsync"}, cur_hs, idle_sync);
    check({tag, "_vsync"}, cur_vs, idle_sync);
    check({tag, "_video_on"}, cur_vo, 1);
    check({tag, "_frame_tick"}, cur_ft, 0);
  endtask

  initial begin
    int unsigned hs_low, hs_first, hs_last, vo_cnt, x_err;

    // Default-timing expectations (active-low syncs)
    tbl[0] = '{2,   0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{639, 0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{640, 0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{655, 0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{656, 0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{700, 0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{751, 0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{752, 0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{799, 0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{0,   1, 1'b1, 1'b1, 1'b1};

    // ---------------- Instance A ----------------
    sel_b = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      check_reset_state("a_reset", 1'b1);
    end
    rst_a = 1'b0;
    release_check(4);

    for (int i = 0; i < 10; i++) begin
      adv_to(tbl[i].x, tbl[i].y, 800);
      check("a_tbl_x", cur_x, tbl[i].x);
      check("a_tbl_y", cur_y, tbl[i].y);
      check("a_tbl_hsync", cur_hs, tbl[i].hs);
      check("a_tbl_vsync", cur_vs, tbl[i].vs);
      check("a_tbl_video_on", cur_vo, tbl[i].vo);
    end

    // One full line, tick by tick
    adv_to(0, 2, 800);
    hs_low = 0; hs_first = 9999; hs_last = 0; vo_cnt = 0; x_err = 0;
    for (int unsigned i = 0; i < 800; i++) begin
      if (cur_x != 10'(i)) x_err++;
      if (cur_hs === 1'b0) begin
        hs_low++;
        if (hs_first == 9999) hs_first = cur_x;
        hs_last = cur_x;
      end
      if (cur_vo === 1'b1) vo_cnt++;
      step_tick();
    end
    mx = 0; my = 3;
    check("a_line_x_sequence_errors", x_err, 0);
    check("a_line_hsync_low_ticks", hs_low, 96);
    check("a_line_hsync_first_x", hs_first, 656);
    check("a_line_hsync_last_x", hs_last, 751);
    check("a_line_video_on_ticks", vo_cnt, 640);
    check("a_line_y_after", cur_y, 3);

    // Reset mid-line while hsync is low and p_tick is high
    adv_to(700, 3, 800);
    wait_pt_high();
    check("a_pre_reset_hsync", cur_hs, 0);
    check("a_pre_reset_ptick", cur_pt, 1);
    rst_a = 1'b1;
    clk_step();
    check_reset_state("a_midreset", 1'b1);
    rst_a = 1'b0;
    release_check(4);

    // ---------------- Instance B ----------------
    sel_b = 1'b1;
    clk_step();
    check_reset_state("b_reset", 1'b0);
    rst_b = 1'b0;
    mon_en = 1'b1;
    release_check(3);

    // Two full frames against a position model
    for (int unsigned i = 0; i < 2 * BH * BV; i++) begin
      check("b_scan_x", cur_x, mx);
      check("b_scan_y", cur_y, my);
      check("b_scan_hsync", cur_hs, (mx >= 10 && mx <= 12) ? 1 : 0);
      check("b_scan_vsync", cur_vs, (my >= 7 && my <= 8) ? 1 : 0);
      check("b_scan_video_on", cur_vo, (mx < 8 && my < 6) ? 1 : 0);
      step_tick();
      if (mx == BH - 1) begin
        mx = 0;
        my = (my == BV - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    mon_en = 1'b0;
    check("b_frame_tick_count", ft_cnt, 2);
    check("b_frame_tick_interval_clks", ft_intv, BH * BV * 3);
    check("b_frame_tick_position_errors", ft_bad, 0);
    check("b_frame_tick_wide_pulses", ft_wide, 0);

    // Reset mid-frame
    adv_to(5, 4, BH);
    wait_pt_high();
    check("b_pre_reset_x", cur_x, 5);
    check("b_pre_reset_y", cur_y, 4);
    rst_b = 1'b1;
    clk_step();
    check_reset_state("b_midreset", 1'b0);
    rst_b = 1'b0;
    release_check(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
